// File: rtl/scalar_wb_pkg.sv
// Shared types, constants and round-robin pick helper for the scalar register-file write-back arbiter.
package scalar_wb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RR_MAX = 8;
    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [4:0]          waddr;
        logic [XLEN_DEF-1:0] wdata;
    } wb_req_t;

    // Returns {found, index}: first set bit of valid at or after ptr, wrapping modulo n.
    function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                           input logic [2:0] ptr,
                                           input int n);
        logic [3:0] res;
        int idx;
        res = '0;
        for (int k = RR_MAX - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (valid[idx]) res = {1'b1, idx[2:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant among valid requests plus the registered search pointer.
module rr_arbiter
    import scalar_wb_pkg::*;
#(
    parameter int N = 3,
    localparam int PW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  valid,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] gidx,
    output logic          any
);

    logic [PW-1:0]     ptr;
    logic [RR_MAX-1:0] valid_ext;
    logic [3:0]        pick;

    always_comb begin
        valid_ext         = '0;
        valid_ext[N-1:0]  = valid;
        pick              = rr_pick(valid_ext, 3'(ptr), N);
        any               = pick[3];
        gidx              = PW'(pick[2:0]);
        grant             = '0;
        if (any) grant[gidx] = 1'b1;
    end

    // Pointer moves past the winner so it has lowest priority next time; holds when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (any) begin
            ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/scalar_wb_arbiter.sv
// Scalar regfile write-back arbiter: per-source one-entry buffers, round-robin drain into a registered write port.
// Optional SCALAR_WB_STATS_EN adds a saturating stat_conflict_cnt output.
module scalar_wb_arbiter
    import scalar_wb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*5-1:0]    req_waddr,
    input  logic [NUM_REQ*XLEN-1:0] req_wdata,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [XLEN-1:0]         rf_wdata,
`ifdef SCALAR_WB_STATS_EN
    output logic [31:0]             stat_conflict_cnt,
`endif
    output logic [31:0]             pending_mask
);

    localparam int PW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] buf_valid;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] fill;
    logic [4:0]         buf_waddr [NUM_REQ];
    logic [XLEN-1:0]    buf_wdata [NUM_REQ];
    logic [PW-1:0]      gidx;
    logic               any_grant;
    logic [31:0]        pend;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (buf_valid),
        .grant (grant),
        .gidx  (gidx),
        .any   (any_grant)
    );

    // Ready comes only from registered state, so a granted buffer can refill on the same edge.
    assign req_ready = ~buf_valid | grant;

    // x0 writes complete the handshake but are dropped here.
    always_comb begin
        fill = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            fill[i] = req_valid[i] & req_ready[i] & (req_waddr[5*i +: 5] != REG_X0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fill[i])       buf_valid[i] <= 1'b1;
                else if (grant[i]) buf_valid[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fill[i]) begin
                buf_waddr[i] <= req_waddr[5*i +: 5];
                buf_wdata[i] <= req_wdata[XLEN*i +: XLEN];
            end
        end
    end

    // Write stage: address and data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= any_grant;
            if (any_grant) begin
                rf_waddr <= buf_waddr[gidx];
                rf_wdata <= buf_wdata[gidx];
            end
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (buf_valid[i]) pend[buf_waddr[i]] = 1'b1;
        end
        if (rf_we) pend[rf_waddr] = 1'b1;
        pend[0] = 1'b0;
    end

    assign pending_mask = pend;

`ifdef SCALAR_WB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_conflict_cnt <= '0;
        end else if (|(buf_valid & ~grant) && (stat_conflict_cnt != 32'hFFFF_FFFF)) begin
            stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
        end
    end
`endif

endmodule
